// File: rtl/store_buffer.sv
// Post-commit store buffer: stores enter uncommitted, are retired in order by
// commit_i, and drain one at a time to the dcache, which holds the head entry until cache_done_i.
module store_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        cpu_clock_i,
  input  logic        cpu_reset_ni,
  input  logic        enq_valid_i,
  input  logic [29:0] enq_address_i,
  input  logic [31:0] enq_data_i,
  input  logic [3:0]  enq_bm_i,
  output logic        enq_ready_o,
  input  logic        commit_i,
  input  logic        flush_i,
  output logic        store_valid_o,
  output logic [29:0] store_address_o,
  output logic [31:0] store_data_o,
  output logic [3:0]  store_bm_o,
  input  logic        cache_done_i,
  input  logic [29:0] ld_check_address_i,
  output logic        ld_conflict_o,
  output logic        empty_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] cmt_q, cmt_d;
  logic [PW-1:0] tail_q, tail_d;

  logic [29:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [3:0]  bm_mem   [DEPTH];

  logic [PW-1:0] count;
  logic [IW-1:0] offset;
  logic          full;
  logic          enq_fire;
  logic          drain;
  logic          do_commit;

  // Pointer update applies drain, commit, flush, enqueue as one step; every
  // decision looks only at the registered pointers so freed slots appear next cycle.
  always_comb begin
    count         = tail_q - head_q;
    full          = (count == PW'(DEPTH));
    enq_ready_o   = !full && !flush_i;
    store_valid_o = (head_q != cmt_q);
    empty_o       = (head_q == tail_q);
    enq_fire      = enq_valid_i && enq_ready_o;
    drain         = cache_done_i && store_valid_o;
    do_commit     = commit_i && (cmt_q != tail_q);

    head_d = head_q;
    cmt_d  = cmt_q;
    tail_d = tail_q;
    if (drain) begin
      head_d = head_q + PW'(1);
    end
    if (do_commit) begin
      cmt_d = cmt_q + PW'(1);
    end
    if (flush_i) begin
      tail_d = cmt_d;
    end else if (enq_fire) begin
      tail_d = tail_q + PW'(1);
    end
  end

  always_comb begin
    store_address_o = addr_mem[head_q[IW-1:0]];
    store_data_o    = data_mem[head_q[IW-1:0]];
    store_bm_o      = bm_mem[head_q[IW-1:0]];
  end

  // A slot is occupied when its distance from head is below the occupancy count.
  always_comb begin
    ld_conflict_o = 1'b0;
    offset        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = IW'(i) - head_q[IW-1:0];
      if (({1'b0, offset} < count) && (addr_mem[i] == ld_check_address_i)) begin
        ld_conflict_o = 1'b1;
      end
    end
  end

  always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
    if (!cpu_reset_ni) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (enq_fire) begin
      addr_mem[tail_q[IW-1:0]] <= enq_address_i;
      data_mem[tail_q[IW-1:0]] <= enq_data_i;
      bm_mem[tail_q[IW-1:0]]   <= enq_bm_i;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain, full, flush, wrap, load conflict and
// asynchronous reset, with expected values worked out by hand.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        enq_valid;
  logic [29:0] enq_address;
  logic [31:0] enq_data;
  logic [3:0]  enq_bm;
  logic        enq_ready;
  logic        commit;
  logic        flush;
  logic        store_valid;
  logic [29:0] store_address;
  logic [31:0] store_data;
  logic [3:0]  store_bm;
  logic        cache_done;
  logic [29:0] ld_check_address;
  logic        ld_conflict;
  logic        empty;

  int checkCount;
  int errorCount;

  store_buffer #(.DEPTH(8)) dut (
    .cpu_clock_i       (clk),
    .cpu_reset_ni      (rst_n),
    .enq_valid_i       (enq_valid),
    .enq_address_i     (enq_address),
    .enq_data_i        (enq_data),
    .enq_bm_i          (enq_bm),
    .enq_ready_o       (enq_ready),
    .commit_i          (commit),
    .flush_i           (flush),
    .store_valid_o     (store_valid),
    .store_address_o   (store_address),
    .store_data_o      (store_data),
    .store_bm_o        (store_bm),
    .cache_done_i      (cache_done),
    .ld_check_address_i(ld_check_address),
    .ld_conflict_o     (ld_conflict),
    .empty_o           (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    enq_valid  = 1'b0;
    commit     = 1'b0;
    flush      = 1'b0;
    cache_done = 1'b0;
  endtask

  task automatic applyStimulus(input logic ev, input logic [29:0] a, input logic [31:0] d,
                               input logic [3:0] bm, input logic cm, input logic fl, input logic cd);
    enq_valid   = ev;
    enq_address = a;
    enq_data    = d;
    enq_bm      = bm;
    commit      = cm;
    flush       = fl;
    cache_done  = cd;
    tick();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enqueue(input logic [29:0] a, input logic [31:0] d, input logic [3:0] bm);
    applyStimulus(1'b1, a, d, bm, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic commitOne();
    applyStimulus(1'b0, 30'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drainOne(input string tag, input logic [29:0] a, input logic [31:0] d, input logic [3:0] bm);
    checkOutput({tag, "_valid"}, 64'(store_valid), 64'd1);
    checkOutput({tag, "_addr"}, 64'(store_address), 64'(a));
    checkOutput({tag, "_data"}, 64'(store_data), 64'(d));
    checkOutput({tag, "_bm"}, 64'(store_bm), 64'(bm));
    applyStimulus(1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [29:0] wa [4];
    logic [31:0] wd [4];
    logic [3:0]  wb [4];
    int          delay;

    checkCount       = 0;
    errorCount       = 0;
    rst_n            = 1'b0;
    enq_valid        = 1'b0;
    enq_address      = '0;
    enq_data         = '0;
    enq_bm           = '0;
    commit           = 1'b0;
    flush            = 1'b0;
    cache_done       = 1'b0;
    ld_check_address = 30'h0;

    // Reset state; ld_check_address matches the never-written address 0 so a
    // broken occupancy test would show up as a conflict here.
    #12;
    checkOutput("rst_valid", 64'(store_valid), 64'd0);
    checkOutput("rst_empty", 64'(empty), 64'd1);
    checkOutput("rst_conflict", 64'(ld_conflict), 64'd0);
    checkOutput("rst_ready", 64'(enq_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Basic drain
    enqueue(30'h0000100, 32'hDEADBEEF, 4'hF);
    checkOutput("basic_not_empty", 64'(empty), 64'd0);
    checkOutput("basic_uncommitted_invalid", 64'(store_valid), 64'd0);
    commitOne();
    checkOutput("basic_hold0_valid", 64'(store_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput("basic_hold_valid", 64'(store_valid), 64'd1);
      checkOutput("basic_hold_data", 64'(store_data), 64'hDEADBEEF);
    end
    drainOne("basic", 30'h0000100, 32'hDEADBEEF, 4'hF);
    checkOutput("basic_after_valid", 64'(store_valid), 64'd0);
    checkOutput("basic_after_empty", 64'(empty), 64'd1);

    // Full: 8 accepted, 9th dropped
    for (int i = 0; i < 8; i++) begin
      checkOutput("full_ready_before", 64'(enq_ready), 64'd1);
      enqueue(30'h200 + 30'(i), 32'hF000_0000 + 32'(i), 4'hF);
    end
    checkOutput("full_ready_low", 64'(enq_ready), 64'd0);
    enqueue(30'h3FF, 32'h9999_9999, 4'hF);
    checkOutput("full_9th_ready_low", 64'(enq_ready), 64'd0);
    commitOne();
    checkOutput("full_head_valid", 64'(store_valid), 64'd1);
    // Drain and enqueue in the same cycle: drain must not free the slot yet
    enq_valid   = 1'b1;
    enq_address = 30'h300;
    enq_data    = 32'h0000_0100;
    enq_bm      = 4'h3;
    cache_done  = 1'b1;
    #1;
    checkOutput("full_same_cycle_ready", 64'(enq_ready), 64'd0);
    tick();
    checkOutput("full_slot_freed", 64'(enq_ready), 64'd1);
    enqueue(30'h300, 32'h0000_0100, 4'h3);
    checkOutput("full_refilled", 64'(enq_ready), 64'd0);
    for (int i = 0; i < 8; i++) commitOne();
    for (int i = 1; i < 8; i++) drainOne("full_drain", 30'h200 + 30'(i), 32'hF000_0000 + 32'(i), 4'hF);
    drainOne("full_drain_last", 30'h300, 32'h0000_0100, 4'h3);
    checkOutput("full_final_empty", 64'(empty), 64'd1);

    // Flush with same-cycle commit
    enqueue(30'h400, 32'hAAAA_0001, 4'h1);
    enqueue(30'h401, 32'hAAAA_0002, 4'h2);
    enqueue(30'h402, 32'hAAAA_0003, 4'h4);
    commitOne();
    commit = 1'b1;
    flush  = 1'b1;
    #1;
    checkOutput("flush_blocks_ready", 64'(enq_ready), 64'd0);
    tick();
    commitOne();
    drainOne("flush_a", 30'h400, 32'hAAAA_0001, 4'h1);
    drainOne("flush_b", 30'h401, 32'hAAAA_0002, 4'h2);
    checkOutput("flush_done_valid", 64'(store_valid), 64'd0);
    checkOutput("flush_done_empty", 64'(empty), 64'd1);

    // Wrap: 20 entries in groups of four, random drain delays
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 4; k++) begin
        wa[k] = 30'h1000 + 30'(g * 4 + k) * 30'd3;
        wd[k] = 32'hC0DE_0000 + 32'(g * 4 + k);
        wb[k] = 4'(g + k) | 4'h1;
        enqueue(wa[k], wd[k], wb[k]);
      end
      for (int k = 0; k < 4; k++) commitOne();
      for (int k = 0; k < 4; k++) begin
        delay = int'($urandom_range(1, 6));
        for (int w = 1; w < delay; w++) begin
          checkOutput("wrap_wait_valid", 64'(store_valid), 64'd1);
          idle();
        end
        drainOne("wrap", wa[k], wd[k], wb[k]);
      end
      checkOutput("wrap_group_empty", 64'(empty), 64'd1);
    end

    // Load conflict
    enqueue(30'h0ABCDE, 32'h1234_5678, 4'hF);
    ld_check_address = 30'h0ABCDE;
    #1;
    checkOutput("conf_uncommitted", 64'(ld_conflict), 64'd1);
    ld_check_address = 30'h0ABCDF;
    #1;
    checkOutput("conf_other_addr", 64'(ld_conflict), 64'd0);
    ld_check_address = 30'h0ABCDE;
    commitOne();
    checkOutput("conf_committed", 64'(ld_conflict), 64'd1);
    drainOne("conf", 30'h0ABCDE, 32'h1234_5678, 4'hF);
    checkOutput("conf_after_drain", 64'(ld_conflict), 64'd0);

    // Asynchronous reset mid-drain
    enqueue(30'h555, 32'h5555_AAAA, 4'h6);
    commitOne();
    checkOutput("arst_pre_valid", 64'(store_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid_drop", 64'(store_valid), 64'd0);
    checkOutput("arst_empty", 64'(empty), 64'd1);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("arst_cd_ignored_valid", 64'(store_valid), 64'd0);
    checkOutput("arst_cd_ignored_empty", 64'(empty), 64'd1);
    enqueue(30'h777, 32'h7777_0000, 4'h8);
    commitOne();
    drainOne("arst_resume", 30'h777, 32'h7777_0000, 4'h8);
    checkOutput("arst_resume_empty", 64'(empty), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
